// File: rtl/pea_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pea_pkg : opcodes, status codes, command fields, FSM encoding       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pea_pkg;

  localparam logic [7:0] OP_STP = 8'h01;
  localparam logic [7:0] OP_EVP = 8'h02;
  localparam logic [7:0] OP_EVB = 8'h03;
  localparam logic [7:0] OP_RST = 8'h05;

  localparam logic [7:0] ST_OK      = 8'd0;
  localparam logic [7:0] ERR_OPCODE = 8'd1;
  localparam logic [7:0] ERR_UNSET  = 8'd2;
  localparam logic [7:0] ERR_DEGREE = 8'd3;
  localparam logic [7:0] ERR_ARG    = 8'd4;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 8;
  localparam int ARG1_MSB = 7;
  localparam int ARG1_LSB = 5;
  localparam int ARG2_MSB = 4;
  localparam int ARG2_LSB = 0;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_STORE      = 3'd1;
  localparam logic [2:0] S_LOAD_X     = 3'd2;
  localparam logic [2:0] S_HORNER     = 3'd3;
  localparam logic [2:0] S_WRITE_RES  = 3'd4;
  localparam logic [2:0] S_WRITE_STAT = 3'd5;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_STP) || (op == OP_EVP) || (op == OP_EVB) || (op == OP_RST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pea_horner_mac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pea_horner_mac : Horner accumulator, acc <= acc*x + coef (2W wrap)  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pea_horner_mac
  import pea_pkg::*;
#(
  parameter int word_size = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     mac_i,
  input  logic [word_size-1:0]     x_i,
  input  logic [word_size-1:0]     coef_i,
  output logic [2*word_size-1:0]   acc_o
);

  localparam int AW = 2 * word_size;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] coef_ext;
  logic [AW-1:0] x_ext;

  assign coef_ext = {{word_size{coef_i[word_size-1]}}, coef_i};
  assign x_ext    = {{word_size{x_i[word_size-1]}}, x_i};

  // Low 2W bits of the product are identical for signed and unsigned operands.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = coef_ext;
    end else if (mac_i) begin
      acc_d = acc_q * x_ext + coef_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/pea_eval_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pea_eval_engine : self-scheduling polynomial store/evaluate core    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pea_eval_engine
  import pea_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int num_slots   = 8,
  parameter int max_degree  = 10,
  localparam int POP_W      = $clog2(buffer_size + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [word_size-1:0]   command_in,
  input  logic [POP_W-1:0]       command_pop,
  input  logic [word_size-1:0]   data_in,
  input  logic [POP_W-1:0]       data_pop,
  input  logic [POP_W-1:0]       result_free_space,
  input  logic [POP_W-1:0]       status_free_space,
  output logic                   command_rd_en,
  output logic                   data_rd_en,
  output logic                   result_wr_en,
  output logic                   status_wr_en,
  output logic [2*word_size-1:0] result_out,
  output logic [2*word_size-1:0] status_out,
  output logic                   busy,
  output logic                   fire_done
);

  localparam int AW     = 2 * word_size;
  localparam int SLOT_W = (num_slots > 1) ? $clog2(num_slots) : 1;
  localparam int DEG_W  = $clog2(max_degree + 1);

  logic [2:0]            state_q;
  logic [num_slots-1:0]  valid_q;
  logic [7:0]            op_q;
  logic [7:0]            code_q;
  logic [2:0]            slot_q;
  logic [4:0]            cnt_q;
  logic [DEG_W-1:0]      k_q;
  logic [DEG_W-1:0]      i_q;
  logic [word_size-1:0]  x_q;
  logic [AW-1:0]         res_q;
  logic [AW-1:0]         stat_q;

  logic [word_size-1:0]  coef_q [num_slots][max_degree+1];
  logic [DEG_W-1:0]      deg_q  [num_slots];

  logic [7:0]            cmd_op;
  logic [2:0]            cmd_a;
  logic [4:0]            cmd_b;
  logic [SLOT_W-1:0]     cmd_slot;
  logic [SLOT_W-1:0]     slot_idx;
  logic [7:0]            err_code;
  logic                  ready;
  logic                  fire;
  logic [DEG_W-1:0]      horner_idx;
  logic [word_size-1:0]  mac_coef;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         stat_word;

  assign cmd_op   = command_in[OPC_MSB:OPC_LSB];
  assign cmd_a    = command_in[ARG1_MSB:ARG1_LSB];
  assign cmd_b    = command_in[ARG2_MSB:ARG2_LSB];
  assign cmd_slot = cmd_a[SLOT_W-1:0];
  assign slot_idx = slot_q[SLOT_W-1:0];

  // Error priority: opcode, argument, degree, unset slot.
  always_comb begin
    err_code = ST_OK;
    if (!is_known_op(cmd_op)) begin
      err_code = ERR_OPCODE;
    end else if (cmd_op != OP_RST &&
                 (int'(cmd_a) >= num_slots || (cmd_op == OP_EVB && cmd_b == 5'd0))) begin
      err_code = ERR_ARG;
    end else if (cmd_op == OP_STP && int'(cmd_b) > max_degree) begin
      err_code = ERR_DEGREE;
    end else if ((cmd_op == OP_EVP || cmd_op == OP_EVB) && !valid_q[cmd_slot]) begin
      err_code = ERR_UNSET;
    end
  end

  always_comb begin
    ready = 1'b0;
    if (err_code != ST_OK || cmd_op == OP_RST) begin
      ready = 1'b1;
    end else if (cmd_op == OP_STP) begin
      ready = int'(data_pop) >= int'(cmd_b) + 1;
    end else if (cmd_op == OP_EVP) begin
      ready = (data_pop != '0) && (result_free_space != '0);
    end else if (cmd_op == OP_EVB) begin
      ready = (int'(data_pop) >= int'(cmd_b)) && (int'(result_free_space) >= int'(cmd_b));
    end
  end

  assign fire = !rst && (state_q == S_IDLE) && (command_pop != '0) &&
                (status_free_space != '0) && ready;

  assign horner_idx = i_q - DEG_W'(1);
  assign mac_coef   = (state_q == S_LOAD_X) ? coef_q[slot_idx][deg_q[slot_idx]]
                                            : coef_q[slot_idx][horner_idx];
  assign stat_word  = {{(AW-16){1'b0}}, op_q, code_q};

  pea_horner_mac #(
    .word_size (word_size)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .load_i (!rst && state_q == S_LOAD_X),
    .mac_i  (!rst && state_q == S_HORNER),
    .x_i    (x_q),
    .coef_i (mac_coef),
    .acc_o  (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      op_q    <= '0;
      code_q  <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      x_q     <= '0;
      res_q   <= '0;
      stat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire) begin
            op_q   <= cmd_op;
            code_q <= err_code;
            slot_q <= cmd_a;
            k_q    <= '0;
            cnt_q  <= (cmd_op == OP_EVP) ? 5'd1 : cmd_b;
            if (err_code != ST_OK) begin
              state_q <= S_WRITE_STAT;
            end else if (cmd_op == OP_STP) begin
              state_q <= S_STORE;
            end else if (cmd_op == OP_EVP || cmd_op == OP_EVB) begin
              state_q <= S_LOAD_X;
            end else begin
              valid_q <= '0;
              state_q <= S_WRITE_STAT;
            end
          end
        end
        S_STORE: begin
          k_q <= k_q + DEG_W'(1);
          if (int'(k_q) == int'(cnt_q)) begin
            valid_q[slot_idx] <= 1'b1;
            state_q           <= S_WRITE_STAT;
          end
        end
        S_LOAD_X: begin
          x_q     <= data_in;
          i_q     <= deg_q[slot_idx];
          state_q <= (deg_q[slot_idx] == '0) ? S_WRITE_RES : S_HORNER;
        end
        S_HORNER: begin
          i_q <= horner_idx;
          if (i_q == DEG_W'(1)) begin
            state_q <= S_WRITE_RES;
          end
        end
        S_WRITE_RES: begin
          res_q <= acc;
          if (cnt_q > 5'd1) begin
            cnt_q   <= cnt_q - 5'd1;
            state_q <= S_LOAD_X;
          end else begin
            state_q <= S_WRITE_STAT;
          end
        end
        S_WRITE_STAT: begin
          stat_q  <= stat_word;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Coefficient storage carries no reset; slot validity gates every read.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_STORE) begin
      coef_q[slot_idx][k_q] <= data_in;
      if (int'(k_q) == int'(cnt_q)) begin
        deg_q[slot_idx] <= k_q;
      end
    end
  end

  assign command_rd_en = fire;
  assign data_rd_en    = !rst && (state_q == S_STORE || state_q == S_LOAD_X);
  assign result_wr_en  = !rst && (state_q == S_WRITE_RES);
  assign status_wr_en  = !rst && (state_q == S_WRITE_STAT);
  assign fire_done     = status_wr_en;
  assign busy          = fire || (!rst && state_q != S_IDLE);
  assign result_out    = rst ? '0 : (result_wr_en ? acc : res_q);
  assign status_out    = rst ? '0 : (status_wr_en ? stat_word : stat_q);

endmodule
`default_nettype wire

// File: tb/tb_pea_eval_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pea_eval_engine : vector table, corner sequences, random vs model|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pea_eval_engine;

  localparam int POP_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       command_in, data_in;
  logic [POP_W-1:0]  command_pop, data_pop, result_free_space, status_free_space;
  logic              command_rd_en, data_rd_en, result_wr_en, status_wr_en, busy, fire_done;
  logic [31:0]       result_out, status_out;

  always #5 clk = ~clk;

  pea_eval_engine dut (
    .clk               (clk),
    .rst               (rst),
    .command_in        (command_in),
    .command_pop       (command_pop),
    .data_in           (data_in),
    .data_pop          (data_pop),
    .result_free_space (result_free_space),
    .status_free_space (status_free_space),
    .command_rd_en     (command_rd_en),
    .data_rd_en        (data_rd_en),
    .result_wr_en      (result_wr_en),
    .status_wr_en      (status_wr_en),
    .result_out        (result_out),
    .status_out        (status_out),
    .busy              (busy),
    .fire_done         (fire_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int res_free = 1024;
  int stat_free = 1024;

  logic [15:0] cq[$];
  logic [15:0] dq[$];
  logic [31:0] got_res[$];
  logic [31:0] got_stat[$];
  logic [31:0] exp_rq[$];
  int          res_cyc[$];
  int          stat_cyc[$];
  int          fire_cyc, n_dpop, n_fire;
  logic        last_busy;
  logic [31:0] last_res, last_stat;

  // Reference model state: plain coefficient lists per slot.
  int mcoef[8][11];
  int mdeg[8];
  bit mvalid[8];
  int mdat[$];

  typedef struct {
    logic [15:0]       cmd;
    int                nd;
    logic [0:3][15:0]  d;
    int                nr;
    logic [0:3][31:0]  r;
    logic [31:0]       st;
    int                rl;
    int                sl;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    command_pop       = POP_W'(cq.size());
    command_in        = (cq.size() > 0) ? cq[0] : 16'h0;
    data_pop          = POP_W'(dq.size());
    data_in           = (dq.size() > 0) ? dq[0] : 16'h0;
    result_free_space = POP_W'(res_free);
    status_free_space = POP_W'(stat_free);
  endtask

  task automatic step();
    logic s_c, s_d;
    logic [15:0] tmp;
    @(negedge clk);
    s_c = command_rd_en;
    s_d = data_rd_en;
    last_busy = busy;
    last_res  = result_out;
    last_stat = status_out;
    if (s_c) begin
      n_fire++;
      fire_cyc = cyc;
      chk("cmd_pop_nonempty", 64'(cq.size() > 0), 64'd1);
    end
    if (s_d) begin
      n_dpop++;
      chk("data_pop_nonempty", 64'(dq.size() > 0), 64'd1);
    end
    if (result_wr_en) begin
      got_res.push_back(result_out);
      res_cyc.push_back(cyc);
    end
    if (status_wr_en) begin
      got_stat.push_back(status_out);
      stat_cyc.push_back(cyc);
      chk("busy_fire_done_at_status", 64'({busy, fire_done}), 64'd3);
    end
    @(posedge clk);
    #1;
    if (s_c && cq.size() > 0) tmp = cq.pop_front();
    if (s_d && dq.size() > 0) tmp = dq.pop_front();
    cyc++;
    drive();
  endtask

  task automatic begin_cmd();
    got_res.delete();
    got_stat.delete();
    res_cyc.delete();
    stat_cyc.delete();
    exp_rq.delete();
    mdat.delete();
    n_dpop   = 0;
    n_fire   = 0;
    fire_cyc = -1000;
  endtask

  task automatic push_data(input logic [15:0] d);
    dq.push_back(d);
    mdat.push_back(int'($signed(d)));
  endtask

  task automatic wait_done(input string nm, input int nd, input logic [31:0] est,
                           input int rl, input int sl);
    int n;
    n = 0;
    while (got_stat.size() == 0 && n < 3000) begin
      step();
      n++;
    end
    chk({nm, "_status_seen"}, 64'(got_stat.size() > 0), 64'd1);
    if (got_stat.size() > 0) begin
      chk({nm, "_status"}, 64'(got_stat[0]), 64'(est));
      if (sl >= 0) chk({nm, "_status_latency"}, 64'(stat_cyc[0] - fire_cyc), 64'(sl));
    end
    chk({nm, "_result_count"}, 64'(got_res.size()), 64'(exp_rq.size()));
    for (int k = 0; k < got_res.size() && k < exp_rq.size(); k++)
      chk($sformatf("%s_result%0d", nm, k), 64'(got_res[k]), 64'(exp_rq[k]));
    if (rl >= 0 && got_res.size() > 0)
      chk({nm, "_result_latency"}, 64'(res_cyc[0] - fire_cyc), 64'(rl));
    chk({nm, "_data_pops"}, 64'(n_dpop), 64'(nd));
    step();
    chk({nm, "_idle_after"}, 64'(last_busy), 64'd0);
  endtask

  function automatic int m_eval(input int a, input int x);
    int acc, pw;
    acc = 0;
    pw  = 1;
    for (int k = 0; k <= mdeg[a]; k++) begin
      acc = acc + mcoef[a][k] * pw;
      pw  = pw * x;
    end
    return acc;
  endfunction

  function automatic logic [7:0] m_code(input logic [15:0] cmd);
    logic [7:0] op;
    int a, b;
    op = cmd[15:8];
    a  = int'(cmd[7:5]);
    b  = int'(cmd[4:0]);
    if (!(op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h05)) return 8'd1;
    if (op != 8'h05 && (a >= 8 || (op == 8'h03 && b == 0))) return 8'd4;
    if (op == 8'h01 && b > 10) return 8'd3;
    if ((op == 8'h02 || op == 8'h03) && !mvalid[a]) return 8'd2;
    return 8'd0;
  endfunction

  function automatic int m_need(input logic [15:0] cmd);
    if (m_code(cmd) != 8'd0) return 0;
    case (cmd[15:8])
      8'h01:   return int'(cmd[4:0]) + 1;
      8'h02:   return 1;
      8'h03:   return int'(cmd[4:0]);
      default: return 0;
    endcase
  endfunction

  // Applies a command to the model; expected results go to exp_rq.
  task automatic m_exec(input logic [15:0] cmd, output logic [31:0] est);
    logic [7:0] code;
    int a, b;
    code = m_code(cmd);
    a    = int'(cmd[7:5]);
    b    = int'(cmd[4:0]);
    est  = {16'h0, cmd[15:8], code};
    if (code == 8'd0) begin
      case (cmd[15:8])
        8'h01: begin
          for (int k = 0; k <= b; k++) mcoef[a][k] = mdat[k];
          mdeg[a]   = b;
          mvalid[a] = 1'b1;
        end
        8'h02: exp_rq.push_back(m_eval(a, mdat[0]));
        8'h03: for (int j = 0; j < b; j++) exp_rq.push_back(m_eval(a, mdat[j]));
        default: for (int s = 0; s < 8; s++) mvalid[s] = 1'b0;
      endcase
    end
  endtask

  initial begin
    logic [31:0] est;
    logic [15:0] cmd;
    logic [7:0]  op;
    int c0, n, sl, b, a, r;

    vt[0]  = '{16'h0122, 3, {16'd3, 16'd2, 16'd1, 16'd0}, 0, {4{32'd0}}, 32'h100, -1, 4};
    vt[1]  = '{16'h0220, 1, {16'd2, 16'd0, 16'd0, 16'd0}, 1, {32'hB, 32'd0, 32'd0, 32'd0}, 32'h200, 4, 5};
    vt[2]  = '{16'h0323, 3, {16'hFFFF, 16'd0, 16'd5, 16'd0}, 3, {32'd2, 32'd3, 32'd38, 32'd0}, 32'h300, 4, 13};
    vt[3]  = '{16'h0280, 0, {4{16'd0}}, 0, {4{32'd0}}, 32'h202, -1, 1};
    vt[4]  = '{16'h0500, 0, {4{16'd0}}, 0, {4{32'd0}}, 32'h500, -1, 1};
    vt[5]  = '{16'h0220, 0, {4{16'd0}}, 0, {4{32'd0}}, 32'h202, -1, 1};
    vt[6]  = '{16'h0700, 0, {4{16'd0}}, 0, {4{32'd0}}, 32'h701, -1, 1};
    vt[7]  = '{16'h0320, 0, {4{16'd0}}, 0, {4{32'd0}}, 32'h304, -1, 1};
    vt[8]  = '{16'h012B, 0, {4{16'd0}}, 0, {4{32'd0}}, 32'h103, -1, 1};
    vt[9]  = '{16'h0100, 1, {16'd7, 16'd0, 16'd0, 16'd0}, 0, {4{32'd0}}, 32'h100, -1, 2};
    vt[10] = '{16'h0200, 1, {16'd5, 16'd0, 16'd0, 16'd0}, 1, {32'd7, 32'd0, 32'd0, 32'd0}, 32'h200, 2, 3};
    vt[11] = '{16'h0161, 2, {16'hFFFE, 16'h7FFF, 16'd0, 16'd0}, 0, {4{32'd0}}, 32'h100, -1, 3};
    vt[12] = '{16'h0260, 1, {16'h7FFF, 16'd0, 16'd0, 16'd0}, 1, {32'h3FFEFFFF, 32'd0, 32'd0, 32'd0}, 32'h200, 3, 4};

    for (int s = 0; s < 8; s++) mvalid[s] = 1'b0;
    begin_cmd();
    rst = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs_zero",
        64'({command_rd_en, data_rd_en, result_wr_en, status_wr_en, busy, fire_done, result_out, status_out}),
        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("post_reset_idle", 64'({last_busy, last_res, last_stat}), 64'd0);

    for (int i = 0; i < 13; i++) begin
      begin_cmd();
      for (int k = 0; k < vt[i].nd; k++) push_data(vt[i].d[k]);
      m_exec(vt[i].cmd, est);
      exp_rq.delete();
      for (int k = 0; k < vt[i].nr; k++) exp_rq.push_back(vt[i].r[k]);
      cq.push_back(vt[i].cmd);
      drive();
      wait_done($sformatf("vec%0d", i), vt[i].nd, vt[i].st, vt[i].rl, vt[i].sl);
    end

    // Status space gates firing.
    begin_cmd();
    stat_free = 0;
    cq.push_back(16'h0500);
    drive();
    repeat (4) step();
    chk("no_fire_without_status_space", 64'(n_fire), 64'd0);
    stat_free = 1024;
    drive();
    c0 = cyc;
    step();
    chk("fire_when_status_space", 64'(fire_cyc), 64'(c0));
    m_exec(16'h0500, est);
    wait_done("rst_after_space", 0, 32'h500, -1, 1);

    begin_cmd();
    push_data(16'd3); push_data(16'd2); push_data(16'd1);
    m_exec(16'h0122, est);
    cq.push_back(16'h0122);
    drive();
    wait_done("stp_reload", 3, est, -1, 4);

    // EVB with only two of three x tokens must wait, then fire next cycle.
    begin_cmd();
    push_data(16'hFFFF); push_data(16'h0000);
    cq.push_back(16'h0323);
    drive();
    repeat (5) step();
    chk("evb_no_fire_short_data", 64'(n_fire), 64'd0);
    push_data(16'd5);
    drive();
    c0 = cyc;
    step();
    chk("evb_fire_after_third", 64'(fire_cyc), 64'(c0));
    m_exec(16'h0323, est);
    wait_done("evb_waited", 3, 32'h300, -1, 13);

    // Result space gates EVP.
    begin_cmd();
    res_free = 0;
    push_data(16'd2);
    cq.push_back(16'h0220);
    drive();
    repeat (4) step();
    chk("evp_no_fire_without_result_space", 64'(n_fire), 64'd0);
    res_free = 1024;
    drive();
    m_exec(16'h0220, est);
    wait_done("evp_after_space", 1, 32'h200, 4, 5);

    // Reset during HORNER of a degree-10 evaluation.
    begin_cmd();
    for (int k = 0; k < 11; k++) push_data(16'($urandom));
    m_exec(16'h014A, est);
    cq.push_back(16'h014A);
    drive();
    wait_done("stp_deg10", 11, 32'h100, -1, 12);
    begin_cmd();
    push_data(16'd3);
    cq.push_back(16'h0240);
    drive();
    n = 0;
    while (n_fire == 0 && n < 20) begin
      step();
      n++;
    end
    chk("deg10_evp_fired", 64'(n_fire), 64'd1);
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_horner_reset_outputs_zero",
        64'({command_rd_en, data_rd_en, result_wr_en, status_wr_en, busy, fire_done, result_out, status_out}),
        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    dq.delete();
    drive();
    for (int s = 0; s < 8; s++) mvalid[s] = 1'b0;
    repeat (20) step();
    chk("no_writes_after_abort", 64'(got_res.size() + got_stat.size()), 64'd0);
    chk("outputs_cleared_after_abort", 64'({last_res, last_stat}), 64'd0);
    begin_cmd();
    m_exec(16'h0240, est);
    cq.push_back(16'h0240);
    drive();
    wait_done("evp_after_abort", 0, 32'h202, -1, 1);

    // Random commands against the reference model.
    for (int t = 0; t < 150; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 32)      op = 8'h01;
      else if (r < 60) op = 8'h02;
      else if (r < 85) op = 8'h03;
      else if (r < 88) op = 8'h05;
      else begin
        op = 8'($urandom);
        while (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h05) op = 8'($urandom);
      end
      a = int'($urandom_range(0, 7));
      if (op == 8'h01)      b = int'($urandom_range(0, 11));
      else if (op == 8'h03) b = int'($urandom_range(0, 4));
      else                  b = int'($urandom_range(0, 31));
      cmd = {op, 3'(a), 5'(b)};
      begin_cmd();
      n = m_need(cmd);
      for (int k = 0; k < n; k++)
        push_data(($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($signed(int'($urandom_range(0, 8)) - 4)));
      if (m_code(cmd) != 8'd0 || op == 8'h05) sl = 1;
      else if (op == 8'h01) sl = b + 2;
      else if (op == 8'h02) sl = mdeg[a] + 3;
      else                  sl = b * (mdeg[a] + 2) + 1;
      m_exec(cmd, est);
      cq.push_back(cmd);
      drive();
      wait_done($sformatf("rand%0d_cmd%04h", t, cmd), n, est, -1, sl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
